int_issue_queue: RTL and testbench

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

---
 rtl/int_issue_queue.sv | 204 ++++++++++++++++++++
 tb/tb_int_issue_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered, compacting reservation station with CDB wakeup
// and oldest-ready selection, issuing at most one instruction per cycle.
module int_issue_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_int_dispatch,
    input  logic [31:0] disp_rs1_data,
    input  logic [31:0] disp_rs2_data,
    input  logic        disp_rs1_pend,
    input  logic        disp_rs2_pend,
    input  logic [5:0]  disp_rs1_tag,
    input  logic [5:0]  disp_rs2_tag,
    input  logic [5:0]  disp_rd_tag,
    input  logic [6:0]  disp_opcode,
    input  logic [2:0]  disp_func3,
    input  logic [6:0]  disp_func7,
    input  logic [31:0] disp_imm,
    input  logic        cdb_valid,
    input  logic [6:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        alu_ready,
    output logic        issueque_int_full,
    output logic        issue_valid,
    output logic [31:0] issue_rs1_data,
    output logic [31:0] issue_rs2_data,
    output logic [5:0]  issue_rd_tag,
    output logic [6:0]  issue_opcode,
    output logic [2:0]  issue_func3,
    output logic [6:0]  issue_func7,
    output logic [31:0] issue_imm,
    output logic [3:0]  iq_count
);

    typedef struct packed {
        logic        valid;
        logic        rs1_pend;
        logic        rs2_pend;
        logic [5:0]  rs1_tag;
        logic [5:0]  rs2_tag;
        logic [5:0]  rd_tag;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // One spare zero entry so the top slot can shift in "empty" uniformly.
    entry_t           woke [DEPTH+1];
    entry_t           new_ent;
    logic [DEPTH-1:0] ready;
    logic             issue_fire;
    logic             disp_acc;
    logic [3:0]       sel_idx;
    logic [3:0]       disp_idx;
    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic             full_q;
    logic             full_d;
    logic [5:0]       cdb_tag_lo;
    logic             unused_cdb_tag_hi;

    logic [31:0] sel_rs1_data;
    logic [31:0] sel_rs2_data;
    logic [5:0]  sel_rd_tag;
    logic [6:0]  sel_opcode;
    logic [2:0]  sel_func3;
    logic [6:0]  sel_func7;
    logic [31:0] sel_imm;

    assign cdb_tag_lo        = cdb_tag[5:0];
    assign unused_cdb_tag_hi = cdb_tag[6];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (cdb_valid && ent_q[i].valid && ent_q[i].rs1_pend &&
                ent_q[i].rs1_tag == cdb_tag_lo) begin
                woke[i].rs1_pend = 1'b0;
                woke[i].rs1_data = cdb_data;
            end
            if (cdb_valid && ent_q[i].valid && ent_q[i].rs2_pend &&
                ent_q[i].rs2_tag == cdb_tag_lo) begin
                woke[i].rs2_pend = 1'b0;
                woke[i].rs2_data = cdb_data;
            end
        end
        woke[DEPTH] = '0;
    end

    // Readiness uses registered state only, so a same-edge wakeup is seen next cycle.
    always_comb begin
        ready        = '0;
        sel_idx      = '0;
        sel_rs1_data = '0;
        sel_rs2_data = '0;
        sel_rd_tag   = '0;
        sel_opcode   = '0;
        sel_func3    = '0;
        sel_func7    = '0;
        sel_imm      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = ent_q[i].valid && !ent_q[i].rs1_pend && !ent_q[i].rs2_pend;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx      = 4'(i);
                sel_rs1_data = ent_q[i].rs1_data;
                sel_rs2_data = ent_q[i].rs2_data;
                sel_rd_tag   = ent_q[i].rd_tag;
                sel_opcode   = ent_q[i].opcode;
                sel_func3    = ent_q[i].func3;
                sel_func7    = ent_q[i].func7;
                sel_imm      = ent_q[i].imm;
            end
        end
        issue_fire = alu_ready && (|ready);
    end

    always_comb begin
        disp_acc = en_int_dispatch && !full_q;
        disp_idx = count_q - {3'b000, issue_fire};

        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.rs1_pend = disp_rs1_pend;
        new_ent.rs2_pend = disp_rs2_pend;
        new_ent.rs1_tag  = disp_rs1_tag;
        new_ent.rs2_tag  = disp_rs2_tag;
        new_ent.rd_tag   = disp_rd_tag;
        new_ent.rs1_data = disp_rs1_data;
        new_ent.rs2_data = disp_rs2_data;
        new_ent.opcode   = disp_opcode;
        new_ent.func3    = disp_func3;
        new_ent.func7    = disp_func7;
        new_ent.imm      = disp_imm;
        // Operand produced by this cycle's broadcast would otherwise miss it.
        if (cdb_valid && disp_rs1_pend && disp_rs1_tag == cdb_tag_lo) begin
            new_ent.rs1_pend = 1'b0;
            new_ent.rs1_data = cdb_data;
        end
        if (cdb_valid && disp_rs2_pend && disp_rs2_tag == cdb_tag_lo) begin
            new_ent.rs2_pend = 1'b0;
            new_ent.rs2_data = cdb_data;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && 4'(i) >= sel_idx) begin
                ent_d[i] = woke[i+1];
            end else begin
                ent_d[i] = woke[i];
            end
            if (disp_acc && 4'(i) == disp_idx) begin
                ent_d[i] = new_ent;
            end
        end

        count_d = count_q + {3'b000, disp_acc} - {3'b000, issue_fire};
        full_d  = (count_d == 4'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q        <= '0;
            full_q         <= 1'b0;
            issue_valid    <= 1'b0;
            issue_rs1_data <= '0;
            issue_rs2_data <= '0;
            issue_rd_tag   <= '0;
            issue_opcode   <= '0;
            issue_func3    <= '0;
            issue_func7    <= '0;
            issue_imm      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q     <= count_d;
            full_q      <= full_d;
            issue_valid <= issue_fire;
            if (issue_fire) begin
                issue_rs1_data <= sel_rs1_data;
                issue_rs2_data <= sel_rs2_data;
                issue_rd_tag   <= sel_rd_tag;
                issue_opcode   <= sel_opcode;
                issue_func3    <= sel_func3;
                issue_func7    <= sel_func7;
                issue_imm      <= sel_imm;
            end
        end
    end

    assign iq_count          = count_q;
    assign issueque_int_full = full_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed vector table and sequences, then random
// traffic compared against a queue-based reference model.
module tb_int_issue_queue;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_int_dispatch;
    logic [31:0] disp_rs1_data, disp_rs2_data;
    logic        disp_rs1_pend, disp_rs2_pend;
    logic [5:0]  disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
    logic [6:0]  disp_opcode;
    logic [2:0]  disp_func3;
    logic [6:0]  disp_func7;
    logic [31:0] disp_imm;
    logic        cdb_valid;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        alu_ready;
    logic        issueque_int_full, issue_valid;
    logic [31:0] issue_rs1_data, issue_rs2_data, issue_imm;
    logic [5:0]  issue_rd_tag;
    logic [6:0]  issue_opcode, issue_func7;
    logic [2:0]  issue_func3;
    logic [3:0]  iq_count;

    int checks = 0;
    int errors = 0;

    int_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en_int_dispatch(en_int_dispatch),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_rs1_pend(disp_rs1_pend), .disp_rs2_pend(disp_rs2_pend),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rd_tag(disp_rd_tag), .disp_opcode(disp_opcode), .disp_func3(disp_func3),
        .disp_func7(disp_func7), .disp_imm(disp_imm), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .alu_ready(alu_ready),
        .issueque_int_full(issueque_int_full), .issue_valid(issue_valid),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode),
        .issue_func3(issue_func3), .issue_func7(issue_func7), .issue_imm(issue_imm),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        p1;
        logic [5:0]  t1;
        logic [31:0] d1;
        logic [5:0]  rd;
        logic        cv;
        logic [6:0]  ct;
        logic [31:0] cd;
        logic        alu;
        logic        e_iv;
        logic [31:0] e_rs1;
        logic [5:0]  e_rd;
        logic [3:0]  e_cnt;
        logic        e_full;
    } vec_t;

    typedef struct {
        logic [31:0] d1, d2, imm;
        logic        p1, p2;
        logic [5:0]  t1, t2, rd;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        m_iv, m_full;
    logic [31:0] m_rs1, m_rs2, m_imm;
    logic [5:0]  m_rd;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    int          m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic en, input logic p1,
                                input logic [5:0] t1, input logic [31:0] d1,
                                input logic [5:0] rd, input logic cv, input logic [6:0] ct,
                                input logic [31:0] cd, input logic alu, input logic e_iv,
                                input logic [31:0] e_rs1, input logic [5:0] e_rd,
                                input logic [3:0] e_cnt, input logic e_full);
        vec_t v;
        v.rst = r; v.en = en; v.p1 = p1; v.t1 = t1; v.d1 = d1; v.rd = rd;
        v.cv = cv; v.ct = ct; v.cd = cd; v.alu = alu;
        v.e_iv = e_iv; v.e_rs1 = e_rs1; v.e_rd = e_rd; v.e_cnt = e_cnt; v.e_full = e_full;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        rst = v.rst; en_int_dispatch = v.en;
        disp_rs1_pend = v.p1; disp_rs1_tag = v.t1; disp_rs1_data = v.d1;
        disp_rs2_pend = 1'b0; disp_rs2_tag = 6'h3E; disp_rs2_data = 32'h0;
        disp_rd_tag = v.rd; disp_opcode = 7'h13; disp_func3 = 3'b000; disp_func7 = 7'h00;
        disp_imm = 32'd3;
        cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd; alu_ready = v.alu;
        @(posedge clk);
        #1;
        check({nm, " issue_valid"}, 32'(issue_valid), 32'(v.e_iv));
        check({nm, " iq_count"}, 32'(iq_count), 32'(v.e_cnt));
        check({nm, " full"}, 32'(issueque_int_full), 32'(v.e_full));
        if (v.e_iv || v.rst) begin
            check({nm, " rs1_data"}, issue_rs1_data, v.e_rs1);
            check({nm, " rd_tag"}, 32'(issue_rd_tag), 32'(v.e_rd));
        end
    endtask

    function automatic vec_t idle(input logic e_iv, input logic [31:0] e_rs1,
                                  input logic [5:0] e_rd, input logic [3:0] e_cnt,
                                  input logic e_full);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e_iv, e_rs1, e_rd, e_cnt, e_full);
    endfunction

    // Reference: plain age-ordered list; issue deletes, dispatch appends.
    task automatic model_step();
        int     pick = -1;
        logic   full_now;
        m_ent_t ne;
        if (rst) begin
            mq.delete();
            m_iv = 1'b0; m_cnt = 0; m_full = 1'b0;
            return;
        end
        if (alu_ready) begin
            for (int k = 0; k < mq.size(); k++) begin
                if (pick < 0 && !mq[k].p1 && !mq[k].p2) pick = k;
            end
        end
        m_iv = (pick >= 0);
        if (m_iv) begin
            m_rs1 = mq[pick].d1; m_rs2 = mq[pick].d2; m_rd = mq[pick].rd;
            m_op = mq[pick].op; m_f3 = mq[pick].f3; m_f7 = mq[pick].f7; m_imm = mq[pick].imm;
        end
        full_now = (mq.size() == DEPTH);
        for (int k = 0; k < mq.size(); k++) begin
            if (cdb_valid && mq[k].p1 && mq[k].t1 == cdb_tag[5:0]) begin
                mq[k].p1 = 1'b0; mq[k].d1 = cdb_data;
            end
            if (cdb_valid && mq[k].p2 && mq[k].t2 == cdb_tag[5:0]) begin
                mq[k].p2 = 1'b0; mq[k].d2 = cdb_data;
            end
        end
        if (m_iv) mq.delete(pick);
        if (en_int_dispatch && !full_now) begin
            ne.d1 = disp_rs1_data; ne.d2 = disp_rs2_data; ne.imm = disp_imm;
            ne.p1 = disp_rs1_pend; ne.p2 = disp_rs2_pend;
            ne.t1 = disp_rs1_tag; ne.t2 = disp_rs2_tag; ne.rd = disp_rd_tag;
            ne.op = disp_opcode; ne.f3 = disp_func3; ne.f7 = disp_func7;
            if (cdb_valid && ne.p1 && ne.t1 == cdb_tag[5:0]) begin
                ne.p1 = 1'b0; ne.d1 = cdb_data;
            end
            if (cdb_valid && ne.p2 && ne.t2 == cdb_tag[5:0]) begin
                ne.p2 = 1'b0; ne.d2 = cdb_data;
            end
            mq.push_back(ne);
        end
        m_cnt = mq.size();
        m_full = (m_cnt == DEPTH);
    endtask

    initial begin
        vec_t tbl[$];

        // ADDI round trip, same-cycle CDB capture at dispatch, younger-ready bypass.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'd5, 6'h0A, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(idle(1, 32'd5, 6'h0A, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 6'h07, 0, 6'h02, 1, 7'h07, 32'h1234, 1, 0, 0, 0, 1, 0));
        tbl.push_back(idle(1, 32'h1234, 6'h02, 0, 0));
        tbl.push_back(mk(0, 1, 1, 6'h20, 0, 6'h03, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h77, 6'h04, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(idle(1, 32'h77, 6'h04, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7'h61, 32'hBAD, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7'h60, 32'hAB, 1, 0, 0, 0, 1, 0));
        tbl.push_back(idle(1, 32'hAB, 6'h03, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Fill with pending entries, drop a 5th, broadcast wakes all, drain oldest-first.
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fill rst");
        for (int i = 0; i < 4; i++)
            run_vec(mk(0, 1, 1, 6'h11, 0, 6'(i + 1), 0, 0, 0, 1, 0, 0, 0, 4'(i + 1), i == 3),
                    $sformatf("fill d%0d", i));
        run_vec(mk(0, 1, 0, 0, 32'h55, 6'h3F, 0, 0, 0, 1, 0, 0, 0, 4, 1), "fill drop");
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, 7'h11, 32'hDEAD, 1, 0, 0, 0, 4, 1), "fill wake");
        for (int i = 0; i < 4; i++)
            run_vec(idle(1, 32'hDEAD, 6'(i + 1), 4'(3 - i), 0), $sformatf("fill i%0d", i));
        run_vec(idle(0, 0, 0, 0, 0), "fill empty");

        // Full with ready head: dispatch dropped, then dispatch+issue keeps count.
        for (int i = 0; i < 4; i++)
            run_vec(mk(0, 1, 0, 0, 32'(100 + i), 6'(16 + i), 0, 0, 0, 0, 0, 0, 0,
                       4'(i + 1), i == 3), $sformatf("fh d%0d", i));
        run_vec(mk(0, 1, 0, 0, 32'h999, 6'h2A, 0, 0, 0, 1, 1, 32'd100, 6'h10, 3, 0), "fh drop");
        run_vec(mk(0, 1, 0, 0, 32'h888, 6'h2B, 0, 0, 0, 1, 1, 32'd101, 6'h11, 3, 0), "fh both");
        run_vec(idle(1, 32'd102, 6'h12, 2, 0), "fh i2");
        run_vec(idle(1, 32'd103, 6'h13, 1, 0), "fh i3");
        run_vec(idle(1, 32'h888, 6'h2B, 0, 0), "fh i4");
        run_vec(mk(0, 1, 0, 0, 32'h1, 6'h05, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mid d0");
        run_vec(mk(0, 1, 1, 6'h09, 32'h2, 6'h06, 0, 0, 0, 0, 0, 0, 0, 2, 0), "mid d1");
        run_vec(mk(1, 1, 0, 0, 32'h777, 6'h2C, 1, 7'h09, 32'h1, 1, 0, 0, 0, 0, 0), "mid rst");
        run_vec(idle(0, 0, 0, 0, 0), "mid after");

        // Random traffic against the reference model.
        rst = 1'b1; model_step();
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            en_int_dispatch = ($urandom_range(0, 99) < 60);
            disp_rs1_pend = 1'($urandom_range(0, 1));
            disp_rs2_pend = 1'($urandom_range(0, 1));
            disp_rs1_tag = 6'($urandom_range(0, 7));
            disp_rs2_tag = 6'($urandom_range(0, 7));
            disp_rs1_data = $urandom; disp_rs2_data = $urandom; disp_imm = $urandom;
            disp_rd_tag = 6'($urandom); disp_opcode = 7'($urandom);
            disp_func3 = 3'($urandom); disp_func7 = 7'($urandom);
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag = {1'($urandom_range(0, 1)), 3'b000, 3'($urandom_range(0, 7))};
            cdb_data = $urandom;
            alu_ready = ($urandom_range(0, 99) < 60);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d issue_valid", n), 32'(issue_valid), 32'(m_iv));
            check($sformatf("rnd%0d iq_count", n), 32'(iq_count), 32'(m_cnt));
            check($sformatf("rnd%0d full", n), 32'(issueque_int_full), 32'(m_full));
            if (m_iv) begin
                check($sformatf("rnd%0d rs1", n), issue_rs1_data, m_rs1);
                check($sformatf("rnd%0d rs2", n), issue_rs2_data, m_rs2);
                check($sformatf("rnd%0d rd", n), 32'(issue_rd_tag), 32'(m_rd));
                check($sformatf("rnd%0d op", n),
                      {15'd0, issue_opcode, issue_func3, issue_func7},
                      {15'd0, m_op, m_f3, m_f7});
                check($sformatf("rnd%0d imm", n), issue_imm, m_imm);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
